complemento_seq: RTL



---
 rtl/alu_pkg.sv | 14 +
 rtl/complemento_chunk.sv | 19 +
 rtl/complemento_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: complement-unit mode encodings and sequencer state type.
package alu_pkg;

  localparam logic [1:0] MODE_ONES = 2'b00;
  localparam logic [1:0] MODE_TWOS = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/complemento_chunk.sv
// One CHUNK-bit slice of the complement datapath: optionally inverted operand plus carry-in.
module complemento_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] d,
  input  logic             inv,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK-1:0] operand;
  logic [CHUNK:0]   total;

  assign operand     = inv ? ~d : d;
  assign total       = {1'b0, operand} + {{CHUNK{1'b0}}, cin};
  assign {cout, sum} = total;

endmodule

// File: rtl/complemento_seq.sv
// Multi-cycle one's/two's complement, absolute value and pass-through unit,
// processing CHUNK bits per clock from the LSB with a rippled carry flop.
module complemento_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done_complemento,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("complemento_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] op_q;
  logic             inv_q, carry_q, ovf_pend_q;
  logic [CHUNK-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] assembled;
  logic             accept, last_chunk, negate;

  assign busy       = (state_q == ST_BUSY);
  assign accept     = (state_q == ST_IDLE) && start;
  assign last_chunk = busy && (idx_q == LAST_IDX);
  assign negate     = (mode == MODE_TWOS) || ((mode == MODE_ABS) && data[WIDTH-1]);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)                state_d = ST_BUSY;
      ST_BUSY: if (idx_q == LAST_IDX)    state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  complemento_chunk #(.CHUNK(CHUNK)) u_chunk (
    .d    (op_q[CHUNK-1:0]),
    .inv  (inv_q),
    .cin  (carry_q),
    .sum  (sum),
    .cout (cout)
  );

  // Finished chunks enter at the top, so after N shifts the LSB chunk sits at bit 0.
  if (N > 1) begin : g_multi
    logic [WIDTH-CHUNK-1:0] acc_q;

    always_ff @(posedge clk) begin
      if (rst)       acc_q <= '0;
      else if (busy) acc_q <= assembled[WIDTH-1:CHUNK];
    end

    assign assembled = {sum, acc_q};
  end else begin : g_single
    assign assembled = sum;
  end

  // NOTE: every datapath register is reset, so an aborted request leaves no stale operand behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q            <= '0;
      op_q             <= '0;
      inv_q            <= 1'b0;
      carry_q          <= 1'b0;
      ovf_pend_q       <= 1'b0;
      result           <= '0;
      overflow         <= 1'b0;
      done_complemento <= 1'b0;
    end else begin
      done_complemento <= 1'b0;
      if (accept) begin
        idx_q      <= '0;
        op_q       <= data;
        inv_q      <= negate || (mode == MODE_ONES);
        carry_q    <= negate;
        ovf_pend_q <= ((mode == MODE_TWOS) || (mode == MODE_ABS)) && (data == MIN_NEG);
      end else if (busy) begin
        idx_q   <= idx_q + 1'b1;
        op_q    <= op_q >> CHUNK;
        carry_q <= cout;
        if (last_chunk) begin
          result           <= assembled;
          overflow         <= ovf_pend_q;
          done_complemento <= 1'b1;
        end
      end
    end
  end

endmodule
